// File: rtl/input_vc_buffer_if.sv
// input_vc_buffer_if: flit input, route-stage output and credit return bundle of input_vc_buffer.
// slave is the buffer's view, master is the upstream/route-stage view.
interface input_vc_buffer_if #(
    parameter int FLIT_SIZE = 64,
    parameter int XW        = 2,
    parameter int YW        = 2,
    parameter int ZW        = 2
);
    logic                 in_valid;
    logic [FLIT_SIZE-1:0] in_flit;
    logic                 stall;
    logic [FLIT_SIZE-1:0] out_flit;
    logic [XW-1:0]        dst_x;
    logic [YW-1:0]        dst_y;
    logic [ZW-1:0]        dst_z;
    logic                 credit_valid;
    logic                 credit_vc;
    logic [1:0]           err;

    modport slave (
        input  in_valid, in_flit, stall,
        output out_flit, dst_x, dst_y, dst_z, credit_valid, credit_vc, err
    );

    modport master (
        output in_valid, in_flit, stall,
        input  out_flit, dst_x, dst_y, dst_z, credit_valid, credit_vc, err
    );
endinterface

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: two-VC input FIFO with wormhole packet lock, round-robin head arbitration and credit return.
// Define INPUT_VC_BUFFER_ERR_CHECK_EN to enable the sticky err flags (overflow, protocol).
module input_vc_buffer #(
    parameter int FLIT_SIZE  = 64,
    parameter int HEADER_LEN = 3,
    parameter int VC_DEPTH   = 4,
    parameter int XW         = 2,
    parameter int YW         = 2,
    parameter int ZW         = 2
) (
    input logic              clk,
    input logic              rst,
    input_vc_buffer_if.slave bus
);
    localparam int AW = $clog2(VC_DEPTH);
    localparam int CB = FLIT_SIZE - HEADER_LEN - 1;
    localparam logic [AW:0] FULL = (AW + 1)'(VC_DEPTH);
    typedef logic [HEADER_LEN-1:0] type_t;
    localparam type_t T_NULL = 0, T_HEAD = 1, T_TAIL = 3, T_SINGLE = 4;
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t               state, state_n;
    logic [FLIT_SIZE-1:0] mem [2][VC_DEPTH];
    logic [FLIT_SIZE-1:0] head [2];
    type_t                head_t [2];
    logic [AW-1:0]        wr_ptr [2], rd_ptr [2];
    logic [AW:0]          count [2];
    logic [1:0]           nonempty, elig, push, acc, popv;
    type_t                in_t, pop_t;
    logic                 in_vc, rr, sel, pop, cred_p, cvc_p;

    always_comb begin
        in_t  = bus.in_flit[FLIT_SIZE-1 -: HEADER_LEN];
        in_vc = bus.in_flit[CB];
        for (int i = 0; i < 2; i++) begin
            head[i]     = mem[i][rd_ptr[i]];
            head_t[i]   = head[i][FLIT_SIZE-1 -: HEADER_LEN];
            nonempty[i] = count[i] != '0;
            elig[i]     = nonempty[i] && (head_t[i] == T_HEAD || head_t[i] == T_SINGLE);
            push[i]     = bus.in_valid && in_t != T_NULL && in_vc == i[0];
        end
    end

    // BODY/TAIL at a VC head in IDLE is never eligible, so it blocks that VC rather than start a packet.
    always_comb begin
        state_n = state;
        sel     = state == IDLE ? (&elig ? rr : elig[1]) : state == LOCK1;
        pop     = !bus.stall && (state == IDLE ? |elig : nonempty[sel]);
        pop_t   = head_t[sel];
        if (pop && state == IDLE && pop_t == T_HEAD)
            state_n = sel ? LOCK1 : LOCK0;
        if (pop && state != IDLE && pop_t == T_TAIL)
            state_n = IDLE;
        for (int i = 0; i < 2; i++) begin
            popv[i] = pop && sel == i[0];
            acc[i]  = push[i] && (count[i] != FULL || popv[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (acc[i]) mem[i][wr_ptr[i]] <= bus.in_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr               <= 1'b0;
            cred_p           <= 1'b0;
            cvc_p            <= 1'b0;
            bus.credit_valid <= 1'b0;
            bus.credit_vc    <= 1'b0;
            bus.out_flit     <= '0;
            bus.dst_x        <= '0;
            bus.dst_y        <= '0;
            bus.dst_z        <= '0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            state            <= state_n;
            cred_p           <= pop;
            bus.credit_valid <= cred_p;
            if (pop) cvc_p <= sel;
            if (cred_p) bus.credit_vc <= cvc_p;
            if (pop && state == IDLE) rr <= ~rr;
            if (!bus.stall) bus.out_flit <= pop ? head[sel] : '0;
            if (pop && (pop_t == T_HEAD || pop_t == T_SINGLE)) begin
                bus.dst_x <= head[sel][CB-1 -: XW];
                bus.dst_y <= head[sel][CB-1-XW -: YW];
                bus.dst_z <= head[sel][CB-1-XW-YW -: ZW];
            end
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (popv[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + (AW + 1)'(acc[i]) - (AW + 1)'(popv[i]);
            end
        end
    end

`ifdef INPUT_VC_BUFFER_ERR_CHECK_EN
    localparam type_t T_BODY = 2;
    logic [1:0] err_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= '0;
        end else begin
            if (|(push & ~acc)) err_r[0] <= 1'b1;
            for (int i = 0; i < 2; i++)
                if (state == IDLE && nonempty[i] && (head_t[i] == T_BODY || head_t[i] == T_TAIL))
                    err_r[1] <= 1'b1;
        end
    end
    assign bus.err = err_r;
`else
    assign bus.err = '0;
`endif
endmodule

// File: tb/tb_input_vc_buffer.sv
// tb_input_vc_buffer: directed per-cycle vector table for input_vc_buffer plus a streaming pointer-wrap sequence.
module tb_input_vc_buffer;
    localparam int N = 0, H = 1, B = 2, T = 3, S = 4;

    typedef struct {
        logic       r, v, s;
        logic [2:0] it, ot;
        logic       ivc, ovc;
        logic [5:0] id, od, ed;
        logic [7:0] itag, otag;
        logic       ecv, ecvc;
        logic [1:0] ee;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0, n_bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    input_vc_buffer_if #(.FLIT_SIZE(64), .XW(2), .YW(2), .ZW(2)) bus ();

    input_vc_buffer dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [5:0] d(int x, int y, int z);
        return {x[1:0], y[1:0], z[1:0]};
    endfunction

    function automatic logic [63:0] mk(int t, int vc, logic [5:0] dd, int tag);
        logic [63:0] f = '0;
        if (t != N) begin
            f[63:61] = 3'(t);
            f[60]    = vc[0];
            f[59:54] = dd;
            f[7:0]   = 8'(tag);
        end
        return f;
    endfunction

    function automatic vec_t mkv(int r, int v, int it, int ivc, logic [5:0] id, int itag, int s,
                                 int ot, int ovc, logic [5:0] od, int otag,
                                 logic [5:0] ed, int ecv, int ecvc, int ee);
        vec_t x;
        x.r = r[0]; x.v = v[0]; x.it = 3'(it); x.ivc = ivc[0]; x.id = id; x.itag = 8'(itag); x.s = s[0];
        x.ot = 3'(ot); x.ovc = ovc[0]; x.od = od; x.otag = 8'(otag);
        x.ed = ed; x.ecv = ecv[0]; x.ecvc = ecvc[0]; x.ee = 2'(ee);
        return x;
    endfunction

    task automatic chk(string nm, int idx, logic [63:0] act, logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_err;
        // Packet H,B,T on VC0 with a SINGLE on VC1 arriving mid-packet; bubble while VC0 runs dry.
        vq.push_back(mkv(1,0,N,0,0,0,0,     N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,H,0,d(1,2,3),1,0, N,0,0,0,         0,0,0,0));
        vq.push_back(mkv(0,1,S,1,d(3,0,1),4,0, H,0,d(1,2,3),1,  d(1,2,3),0,0,0));
        vq.push_back(mkv(0,1,B,0,0,2,0,     N,0,0,0,            d(1,2,3),1,0,0));
        vq.push_back(mkv(0,1,T,0,0,3,0,     B,0,0,2,            d(1,2,3),0,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     T,0,0,3,            d(1,2,3),1,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,1,d(3,0,1),4,     d(3,0,1),1,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(3,0,1),1,1,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(3,0,1),0,0,0));
        // Overflow VC1 under stall; the push that coincides with a pop of a full VC is accepted.
        vq.push_back(mkv(1,0,N,0,0,0,0,     N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,S,0,d(3,3,3),'h20,0, N,0,0,0,      0,0,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,0,d(3,3,3),'h20,  d(3,3,3),0,0,0));
        vq.push_back(mkv(0,1,S,1,d(0,1,2),'h21,1, S,0,d(3,3,3),'h20, d(3,3,3),1,0,0));
        vq.push_back(mkv(0,1,S,1,d(1,1,1),'h22,1, S,0,d(3,3,3),'h20, d(3,3,3),0,0,0));
        vq.push_back(mkv(0,1,S,1,d(2,2,2),'h23,1, S,0,d(3,3,3),'h20, d(3,3,3),0,0,0));
        vq.push_back(mkv(0,1,S,1,d(0,0,1),'h24,1, S,0,d(3,3,3),'h20, d(3,3,3),0,0,0));
        vq.push_back(mkv(0,1,S,1,d(1,0,0),'h25,1, S,0,d(3,3,3),'h20, d(3,3,3),0,0,1));
        vq.push_back(mkv(0,1,S,1,d(2,0,3),'h26,0, S,1,d(0,1,2),'h21, d(0,1,2),0,0,1));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,1,d(1,1,1),'h22,  d(1,1,1),1,1,1));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,1,d(2,2,2),'h23,  d(2,2,2),1,1,1));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,1,d(0,0,1),'h24,  d(0,0,1),1,1,1));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,1,d(2,0,3),'h26,  d(2,0,3),1,1,1));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(2,0,3),1,1,1));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(2,0,3),0,0,1));
        // BODY stuck at VC0 head in IDLE; VC1 still served.
        vq.push_back(mkv(1,0,N,0,0,0,0,     N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,B,0,0,'h30,0,  N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,S,1,d(1,2,3),'h31,0, N,0,0,0,      0,0,0,2));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,1,d(1,2,3),'h31,  d(1,2,3),0,0,2));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(1,2,3),1,1,2));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(1,2,3),0,0,2));
        // Reset while LOCKED on VC0 with three flits buffered.
        vq.push_back(mkv(1,0,N,0,0,0,0,     N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,H,0,d(1,1,1),'h40,0, N,0,0,0,      0,0,0,0));
        vq.push_back(mkv(0,1,B,0,0,'h41,0,  H,0,d(1,1,1),'h40,  d(1,1,1),0,0,0));
        vq.push_back(mkv(0,1,B,0,0,'h42,1,  H,0,d(1,1,1),'h40,  d(1,1,1),1,0,0));
        vq.push_back(mkv(0,1,T,0,0,'h43,1,  H,0,d(1,1,1),'h40,  d(1,1,1),0,0,0));
        vq.push_back(mkv(1,0,N,0,0,0,0,     N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,S,1,d(2,2,2),'h50,0, N,0,0,0,      0,0,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     S,1,d(2,2,2),'h50,  d(2,2,2),0,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(2,2,2),1,1,0));
        // HEADs on both VCs at once after reset: VC0 packet, then VC1 packet.
        vq.push_back(mkv(1,0,N,0,0,0,0,     N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,H,0,d(2,1,0),'h10,1, N,0,0,0,      0,0,0,0));
        vq.push_back(mkv(0,1,H,1,d(1,3,2),'h11,1, N,0,0,0,      0,0,0,0));
        vq.push_back(mkv(0,1,T,1,0,'h13,1,  N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,1,T,0,0,'h12,1,  N,0,0,0,            0,0,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     H,0,d(2,1,0),'h10,  d(2,1,0),0,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     T,0,0,'h12,         d(2,1,0),1,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     H,1,d(1,3,2),'h11,  d(1,3,2),1,0,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     T,1,0,'h13,         d(1,3,2),1,1,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(1,3,2),1,1,0));
        vq.push_back(mkv(0,0,N,0,0,0,0,     N,0,0,0,            d(1,3,2),0,0,0));

        foreach (vq[i]) begin
            rst          = vq[i].r;
            bus.in_valid = vq[i].v;
            bus.in_flit  = vq[i].v ? mk(int'(vq[i].it), int'(vq[i].ivc), vq[i].id, int'(vq[i].itag)) : '0;
            bus.stall    = vq[i].s;
            @(posedge clk);
            #1;
            n_vec++;
`ifdef INPUT_VC_BUFFER_ERR_CHECK_EN
            exp_err = vq[i].ee;
`else
            exp_err = 2'b00;
`endif
            chk("out_flit", i, bus.out_flit, mk(int'(vq[i].ot), int'(vq[i].ovc), vq[i].od, int'(vq[i].otag)));
            chk("dst", i, 64'({bus.dst_x, bus.dst_y, bus.dst_z}), 64'(vq[i].ed));
            chk("credit_valid", i, 64'(bus.credit_valid), 64'(vq[i].ecv));
            if (vq[i].ecv) chk("credit_vc", i, 64'(bus.credit_vc), 64'(vq[i].ecvc));
            chk("err", i, 64'(bus.err), 64'(exp_err));
        end

        // Streaming SINGLEs alternating VCs: one-cycle latency and pointer wrap past VC_DEPTH.
        rst = 1'b1; bus.in_valid = 1'b0; bus.in_flit = '0; bus.stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            int p, c;
            p = k - 1;
            c = k - 2;
            bus.in_valid = k < 10;
            bus.in_flit  = k < 10 ? mk(S, k % 2, d(k % 4, (k + 1) % 4, (k + 2) % 4), 'h60 + k) : '0;
            @(posedge clk);
            #1;
            n_vec++;
            if (k == 0) chk("stream_out", k, bus.out_flit, 64'd0);
            else begin
                chk("stream_out", k, bus.out_flit, mk(S, p % 2, d(p % 4, (p + 1) % 4, (p + 2) % 4), 'h60 + p));
                chk("stream_dst", k, 64'({bus.dst_x, bus.dst_y, bus.dst_z}), 64'(d(p % 4, (p + 1) % 4, (p + 2) % 4)));
            end
            chk("stream_cv", k, 64'(bus.credit_valid), 64'(k >= 2));
            if (k >= 2) chk("stream_cvc", k, 64'(bus.credit_vc), 64'(c % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
